alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Requester side of the ALU interface. Accepts one decoded-operand instruction per handshake.
//  Maps opcode/funct to an ALU OPRN code, builds OP1/OP2 and drives the combinational ALU.
//  Captures OUT/ZERO after a settle window and returns the result with its writeback info.
//  Sits between the register-read stage and writeback in the datapath.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles ALU_OP1/OP2/OPRN are held stable before OUT/ZERO is captured (legal range 1..15)
// PORTS
//  CLK          in   1   clock; all state changes on the rising edge
//  RST          in   1   synchronous, active-high reset
//  REQ_VALID    in   1   request present
//  REQ_READY    out  1   block can accept a request (combinational: high only in IDLE)
//  REQ_INSTR    in   32  instruction word
//  REQ_RS_DATA  in   32  register rs value
//  REQ_RT_DATA  in   32  register rt value
//  ALU_OP1      out  32  to ALU OP1, registered
//  ALU_OP2      out  32  to ALU OP2, registered
//  ALU_OPRN     out  6   to ALU OPRN, registered
//  ALU_OUT      in   32  from ALU OUT
//  ALU_ZERO     in   1   from ALU ZERO
//  RSP_VALID    out  1   response present
//  RSP_READY    in   1   consumer accepts response
//  RSP_RESULT   out  32  captured ALU_OUT
//  RSP_ZERO     out  1   captured ALU_ZERO
//  RSP_DEST     out  5   writeback register address
//  RSP_WE       out  1   writeback enable
//  RSP_ILLEGAL  out  1   instruction has no ALU mapping
// BEHAVIOUR
//  Reset: state IDLE; ALU_OP1/OP2=0; ALU_OPRN=0 (ALU no-op); all RSP_* outputs 0.
//  Reset mid-transaction discards the transaction. No response is produced.
//  FSM states: IDLE, EXEC, RESP.
//   IDLE: REQ_READY=1. On REQ_VALID: latch the request, load the ALU_* registers and the settle counter
//         with SETTLE_CYCLES, then go to EXEC. An illegal request goes straight to RESP instead.
//   EXEC: ALU_* held constant. The counter decrements each cycle. At count 1: capture ALU_OUT/ALU_ZERO
//         into RSP_RESULT/RSP_ZERO, set RSP_VALID, go to RESP.
//   RESP: RSP_VALID and all RSP_* outputs held stable until RSP_READY. On RSP_VALID&&RSP_READY:
//         clear RSP_VALID and go to IDLE. No request is accepted in the same cycle.
//  Latency: accept at edge k; RSP_VALID high after edge k+SETTLE_CYCLES. Throughput 1 op per SETTLE_CYCLES+2 cycles.
//  Decode, R-type (op=0x00), OPRN by funct; RSP_DEST=rd[15:11]; OP1=rs, OP2=rt:
//   add 0x20->1, sub 0x22->2, mul 0x2c->3, and 0x24->6, or 0x25->7, nor 0x27->8, slt 0x2a->9.
//   Shifts: srl 0x02->4, sll 0x00->5, with OP1=rt and OP2={27'b0,shamt[10:6]}.
//  Decode, I-type; RSP_DEST=rt[20:16]; OP1=rs:
//   addi 0x08->1, muli 0x1d->3, slti 0x0a->9: OP2 = sign-extended imm.
//   andi 0x0c->6, ori 0x0d->7: OP2 = zero-extended imm.
//   lui 0x0f->5: OP1 = zero-extended imm, OP2 = 16.
//   beq 0x04, bne 0x05 ->2: OP1=rs, OP2=rt, RSP_WE=0. The consumer uses RSP_ZERO.
//  RSP_WE=1 for every legal non-branch op.
//  Any other op/funct is illegal: RSP_ILLEGAL=1, RSP_RESULT=0, RSP_ZERO=0, RSP_WE=0; ALU_* not reloaded.
//  RSP_ILLEGAL is cleared on the next accepted request.
//  REQ_VALID while not in IDLE is ignored (REQ_READY=0). The requester must hold it.
// STRUCTURE
//  Add to prj_definition.v: ALU OPRN codes (`ALU_ADD..`ALU_SLT),
//  instruction opcode/funct constants, and FSM state encodings.
//  Sub-module alu_instr_decode: combinational.
//   in:  instr, rs, rt
//   out: oprn, op1, op2, dest, we, illegal
//  Top: FSM, settle counter, ALU_* and RSP_* registers.
// TESTING
//  Reset held 2 cycles, then released -> all outputs 0, REQ_READY=1.
//  add rs=5,rt=7,rd=3 -> ALU_OPRN=1, ALU_OP1=5, ALU_OP2=7;
//   after 1+SETTLE edges RSP_RESULT=12, RSP_DEST=3, RSP_WE=1.
//  addi imm=0xFFFF, rs=1 -> ALU_OP2=0xFFFFFFFF, RSP_RESULT=0, RSP_ZERO=1.
//  andi imm=0xFFFF -> ALU_OP2=0x0000FFFF.
//  lui imm=0x1234 -> ALU_OPRN=5, OP1=0x1234, OP2=16, RSP_RESULT=0x12340000.
//  beq rs=rt=9 -> RSP_ZERO=1, RSP_WE=0.
//   Then hold RSP_READY=0 for 5 cycles -> outputs stable, REQ_READY=0.
//  op=0x3f -> RSP_VALID one cycle after accept, RSP_ILLEGAL=1, ALU_OPRN unchanged.
//   Then assert RST while in EXEC -> IDLE next cycle, no RSP_VALID.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_pkg
//  Purpose  : Shared definitions for the ALU issue controller: ALU operation
//             codes, instruction opcode/funct values, FSM state encoding and
//             an immediate sign-extension helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

   // Settle counter width covers SETTLE_CYCLES up to 15
   localparam int unsigned CNT_W = 4;

   // ALU operation codes presented on the OPRN bus
   localparam logic [5:0] OPRN_NOP = 6'd0;
   localparam logic [5:0] OPRN_ADD = 6'd1;
   localparam logic [5:0] OPRN_SUB = 6'd2;
   localparam logic [5:0] OPRN_MUL = 6'd3;
   localparam logic [5:0] OPRN_SRL = 6'd4;
   localparam logic [5:0] OPRN_SLL = 6'd5;
   localparam logic [5:0] OPRN_AND = 6'd6;
   localparam logic [5:0] OPRN_OR  = 6'd7;
   localparam logic [5:0] OPRN_NOR = 6'd8;
   localparam logic [5:0] OPRN_SLT = 6'd9;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_MULI  = 6'h1d;

   // R-type funct codes
   localparam logic [5:0] F_SLL = 6'h00;
   localparam logic [5:0] F_SRL = 6'h02;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_NOR = 6'h27;
   localparam logic [5:0] F_SLT = 6'h2a;
   localparam logic [5:0] F_MUL = 6'h2c;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_if
//  Purpose  : Request, ALU and response signal bundle of the ALU issue
//             controller.
//  Ports    : req_*  - decoded-operand instruction handshake (valid/ready)
//             alu_*  - operands/operation to and result from the ALU
//             rsp_*  - result and writeback info handshake (valid/ready)
//  Modports : master - the issue controller
//             slave  - the surrounding datapath (register read, ALU, WB)
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_instr;
   logic [31:0] req_rs_data;
   logic [31:0] req_rt_data;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic [5:0]  alu_oprn;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic [4:0]  rsp_dest;
   logic        rsp_we;
   logic        rsp_illegal;

   modport master (
      input  req_valid, req_instr, req_rs_data, req_rt_data, alu_out, alu_zero, rsp_ready,
      output req_ready, alu_op1, alu_op2, alu_oprn,
      output rsp_valid, rsp_result, rsp_zero, rsp_dest, rsp_we, rsp_illegal
   );

   modport slave (
      output req_valid, req_instr, req_rs_data, req_rt_data, alu_out, alu_zero, rsp_ready,
      input  req_ready, alu_op1, alu_op2, alu_oprn,
      input  rsp_valid, rsp_result, rsp_zero, rsp_dest, rsp_we, rsp_illegal
   );
endinterface
`default_nettype wire

// File: rtl/alu_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_instr_decode
//  Purpose  : Combinational instruction decode: maps opcode/funct to an ALU
//             operation and builds the two ALU operands plus writeback info.
//  Ports    : instr_i   - instruction word
//             rs_i/rt_i - register operand values
//             oprn_o    - ALU operation code
//             op1_o/op2_o - ALU operands
//             dest_o    - writeback register address
//             we_o      - writeback enable
//             illegal_o - instruction has no ALU mapping
//  Revision : 1.0 - initial release
// ============================================================================
module alu_instr_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic [5:0]  oprn_o,
   output logic [31:0] op1_o,
   output logic [31:0] op2_o,
   output logic [4:0]  dest_o,
   output logic        we_o,
   output logic        illegal_o
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt_f;
   logic [4:0]  rd_f;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic        unused_rs_field;

   assign opcode = instr_i[31:26];
   assign rt_f   = instr_i[20:16];
   assign rd_f   = instr_i[15:11];
   assign shamt  = instr_i[10:6];
   assign funct  = instr_i[5:0];
   assign imm    = instr_i[15:0];
   // The rs register index is resolved upstream; its value arrives on rs_i
   assign unused_rs_field = ^instr_i[25:21];

   always_comb begin
      oprn_o    = OPRN_NOP;
      op1_o     = rs_i;
      op2_o     = rt_i;
      dest_o    = 5'd0;
      we_o      = 1'b0;
      illegal_o = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dest_o = rd_f;
            we_o   = 1'b1;
            case (funct)
               F_ADD: oprn_o = OPRN_ADD;
               F_SUB: oprn_o = OPRN_SUB;
               F_MUL: oprn_o = OPRN_MUL;
               F_AND: oprn_o = OPRN_AND;
               F_OR:  oprn_o = OPRN_OR;
               F_NOR: oprn_o = OPRN_NOR;
               F_SLT: oprn_o = OPRN_SLT;
               // Shifts move rt by the shamt field rather than by rt
               F_SRL: begin
                  oprn_o = OPRN_SRL;
                  op1_o  = rt_i;
                  op2_o  = {27'b0, shamt};
               end
               F_SLL: begin
                  oprn_o = OPRN_SLL;
                  op1_o  = rt_i;
                  op2_o  = {27'b0, shamt};
               end
               default: begin
                  dest_o    = 5'd0;
                  we_o      = 1'b0;
                  illegal_o = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_MULI, OP_SLTI: begin
            oprn_o = (opcode == OP_ADDI) ? OPRN_ADD :
                     (opcode == OP_MULI) ? OPRN_MUL : OPRN_SLT;
            op2_o  = sext16(imm);
            dest_o = rt_f;
            we_o   = 1'b1;
         end
         OP_ANDI, OP_ORI: begin
            oprn_o = (opcode == OP_ANDI) ? OPRN_AND : OPRN_OR;
            op2_o  = {16'b0, imm};
            dest_o = rt_f;
            we_o   = 1'b1;
         end
         // lui is built as imm << 16 on the shifter
         OP_LUI: begin
            oprn_o = OPRN_SLL;
            op1_o  = {16'b0, imm};
            op2_o  = 32'd16;
            dest_o = rt_f;
            we_o   = 1'b1;
         end
         // Branches only compare; the consumer looks at the zero flag
         OP_BEQ, OP_BNE: begin
            oprn_o = OPRN_SUB;
            dest_o = rt_f;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Requester side of a combinational ALU. Accepts one decoded-
//             operand instruction, drives registered operands to the ALU,
//             captures its result after a settle window and returns it with
//             writeback info.
//  Ports    : clk_i - clock, rising edge
//             rst_i - synchronous active-high reset
//             bus   - request / ALU / response bundle (master view)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
)(
   input  logic             clk_i,
   input  logic             rst_i,
   alu_issue_ctrl_if.master bus
);

   localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      op1_q, op1_d, op2_q, op2_d;
   logic [5:0]       oprn_q, oprn_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic [4:0]       rsp_dest_q, rsp_dest_d;
   logic             rsp_we_q, rsp_we_d;
   logic             rsp_illegal_q, rsp_illegal_d;

   logic [5:0]  dec_oprn;
   logic [31:0] dec_op1, dec_op2;
   logic [4:0]  dec_dest;
   logic        dec_we, dec_illegal;

   alu_instr_decode u_decode (
      .instr_i   (bus.req_instr),
      .rs_i      (bus.req_rs_data),
      .rt_i      (bus.req_rt_data),
      .oprn_o    (dec_oprn),
      .op1_o     (dec_op1),
      .op2_o     (dec_op2),
      .dest_o    (dec_dest),
      .we_o      (dec_we),
      .illegal_o (dec_illegal)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         op1_q         <= '0;
         op2_q         <= '0;
         oprn_q        <= OPRN_NOP;
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_dest_q    <= '0;
         rsp_we_q      <= 1'b0;
         rsp_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op1_q         <= op1_d;
         op2_q         <= op2_d;
         oprn_q        <= oprn_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_dest_q    <= rsp_dest_d;
         rsp_we_q      <= rsp_we_d;
         rsp_illegal_q <= rsp_illegal_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op1_d         = op1_q;
      op2_d         = op2_q;
      oprn_d        = oprn_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_dest_d    = rsp_dest_q;
      rsp_we_d      = rsp_we_q;
      rsp_illegal_d = rsp_illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               rsp_illegal_d = dec_illegal;
               rsp_dest_d    = dec_dest;
               rsp_we_d      = dec_we;
               if (dec_illegal) begin
                  // No ALU work: answer immediately, leave the ALU operands untouched
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b0;
                  rsp_valid_d  = 1'b1;
                  state_d      = ST_RESP;
               end else begin
                  op1_d   = dec_op1;
                  op2_d   = dec_op2;
                  oprn_d  = dec_oprn;
                  cnt_d   = SETTLE_INIT;
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (cnt_q == CNT_W'(1)) begin
               rsp_result_d = bus.alu_out;
               rsp_zero_d   = bus.alu_zero;
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.req_ready   = (state_q == ST_IDLE);
   assign bus.alu_op1     = op1_q;
   assign bus.alu_op2     = op2_q;
   assign bus.alu_oprn    = oprn_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_zero    = rsp_zero_q;
   assign bus.rsp_dest    = rsp_dest_q;
   assign bus.rsp_we      = rsp_we_q;
   assign bus.rsp_illegal = rsp_illegal_q;

endmodule
`default_nettype wire
